// File: rtl/bch_syndrome_sequencer.sv
// ---------------------------------------------------------------------------
// bch_syndrome_sequencer
//
// Feeds a received BCH codeword into a bank of method-1 syndrome accumulators.
// The bank instances share start/ce/data_in. Codeword bits arrive BITS per
// beat over a valid/ready handshake. Beat 0 pulses syn_start and the
// remaining beats pulse syn_ce. Pad lanes on the final beat are forced to
// zero. Once the last beat has been written, syn_valid is held until the
// error locator acknowledges with syn_ack.
//
// Parameters
//   N      codeword length in bits (N >= BITS)
//   BITS   codeword bits per beat (BITS >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat present
//   in_ready   beat accepted when in_valid & in_ready ("fire")
//   in_data    codeword bits, lane 0 first in codeword order
//   syn_start  bank start strobe (fire of beat 0)
//   syn_ce     bank clock-enable strobe (fire of beats 1..BEATS-1)
//   syn_data   bank data_in: in_data with pad lanes masked on the last beat
//   syn_valid  bank holds a complete codeword's syndromes
//   syn_ack    downstream consumed the syndromes (only seen in HOLD)
//   busy       codeword partially received
//   beat       index of the next beat expected
//   abort      synchronous codeword abort (only with BCH_SYN_SEQ_ABORT_EN)
//
// Build option: define BCH_SYN_SEQ_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module bch_syndrome_sequencer #(
   parameter  int N     = 15,
   parameter  int BITS  = 1,
   localparam int BEATS = (N + BITS - 1) / BITS,
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_data,
   output logic            syn_start,
   output logic            syn_ce,
   output logic [BITS-1:0] syn_data,
   output logic            syn_valid,
   input  logic            syn_ack,
`ifdef BCH_SYN_SEQ_ABORT_EN
   input  logic            abort,
`endif
   output logic            busy,
   output logic [CW-1:0]   beat
);

   // Number of real codeword lanes carried by the final beat.
   localparam int            LAST_LANES = N - (BEATS - 1) * BITS;
   localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);

   function automatic logic [BITS-1:0] last_beat_mask();
      logic [BITS-1:0] m;
      for (int i = 0; i < BITS; i++) begin
         m[i] = (i < LAST_LANES);
      end
      return m;
   endfunction

   localparam logic [BITS-1:0] LAST_MASK = last_beat_mask();

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] beat_q, beat_d;
   logic          fire;
   logic          abort_run;

`ifdef BCH_SYN_SEQ_ABORT_EN
   assign abort_run = abort & (state_q == S_RUN);
`else
   assign abort_run = 1'b0;
`endif

   // Ready is combinational from syn_ack so that a HOLD cycle can release
   // the old result and start the next codeword at the same edge.
   assign in_ready  = ((state_q != S_HOLD) | syn_ack) & ~abort_run;
   assign fire      = in_valid & in_ready;
   assign syn_start = fire & (state_q != S_RUN);
   assign syn_ce    = fire & (state_q == S_RUN);
   assign syn_data  = (beat_q == LAST_BEAT) ? (in_data & LAST_MASK) : in_data;
   assign syn_valid = (state_q == S_HOLD);
   assign busy      = (state_q == S_RUN);
   assign beat      = beat_q;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      unique case (state_q)
         S_IDLE: begin
            if (fire) begin
               if (BEATS == 1) begin
                  state_d = S_HOLD;
                  beat_d  = '0;
               end else begin
                  state_d = S_RUN;
                  beat_d  = CW'(1);
               end
            end
         end
         S_RUN: begin
            if (abort_run) begin
               state_d = S_IDLE;
               beat_d  = '0;
            end else if (fire) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = S_HOLD;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + CW'(1);
               end
            end
         end
         S_HOLD: begin
            // A fire here is necessarily acked: it is beat 0 of the next word.
            if (fire) begin
               if (BEATS == 1) begin
                  state_d = S_HOLD;
                  beat_d  = '0;
               end else begin
                  state_d = S_RUN;
                  beat_d  = CW'(1);
               end
            end else if (syn_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_bch_syndrome_sequencer.sv
module tb_bch_syndrome_sequencer;

   localparam int NCW = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT with one bit per beat
   logic       v1 = 1'b0, ack1 = 1'b0, ab1 = 1'b0;
   logic [0:0] d1 = '0;
   logic       r1, st1, ce1, sv1, busy1;
   logic [0:0] sd1;
   logic [3:0] beat1;

   // DUT with four bits per beat
   logic       v4 = 1'b0, ack4 = 1'b0, ab4 = 1'b0;
   logic [3:0] d4 = '0;
   logic       r4, st4, ce4, sv4, busy4;
   logic [3:0] sd4;
   logic [1:0] beat4;

   bch_syndrome_sequencer #(.N(NCW), .BITS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
      .syn_start(st1), .syn_ce(ce1), .syn_data(sd1), .syn_valid(sv1),
      .syn_ack(ack1),
`ifdef BCH_SYN_SEQ_ABORT_EN
      .abort(ab1),
`endif
      .busy(busy1), .beat(beat1));

   bch_syndrome_sequencer #(.N(NCW), .BITS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
      .syn_start(st4), .syn_ce(ce4), .syn_data(sd4), .syn_valid(sv4),
      .syn_ack(ack4),
`ifdef BCH_SYN_SEQ_ABORT_EN
      .abort(ab4),
`endif
      .busy(busy4), .beat(beat4));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks how many beats of the current codeword have been taken and
   // whether a finished result is waiting for acknowledgement.
   typedef struct {
      bit rdy, st, ce, sv, busy, fire;
      int beat;
      logic [3:0] sd;
   } exp_t;

   function automatic exp_t mdl(int cnt, bit held, bit v, bit ack, bit ab,
                                logic [3:0] din, int bits);
      exp_t e;
      bit running;
      running = !held && cnt > 0;
      e.rdy  = (!held || ack) && !(ab && running);
      e.fire = v && e.rdy;
      e.st   = e.fire && cnt == 0;
      e.ce   = e.fire && cnt > 0;
      e.sv   = held;
      e.busy = running;
      e.beat = cnt;
      e.sd   = '0;
      for (int i = 0; i < bits; i++)
         if (cnt * bits + i < NCW) e.sd[i] = din[i];
      return e;
   endfunction

   task automatic adv(inout int cnt, inout bit held, input bit ab, input bit fire,
                      input bit ack, input int beats);
      if (ab && !held && cnt > 0) begin
         cnt = 0;
      end else if (fire) begin
         cnt++;
         held = 0;
         if (cnt == beats) begin
            cnt = 0;
            held = 1;
         end
      end else if (held && ack) begin
         held = 0;
      end
   endtask

   int cnt1 = 0, cnt4 = 0, pos1 = 0, pos4 = 0, stc1 = 0, cec1 = 0;
   bit held1 = 0, held4 = 0, psv1 = 0, psv4 = 0;
   logic [15:0] bank1 = '0, bank4 = '0;
   logic [14:0] q1[$];
   logic [14:0] q4[$];

   always @(negedge clk) begin : mon1
      exp_t e;
      logic [14:0] x;
      if (!rst_n) begin
         cnt1 = 0; held1 = 0; pos1 = 0; psv1 = 0; q1.delete();
      end
      e = mdl(cnt1, held1, v1, ack1, ab1, {3'b0, d1}, 1);
      chk("u1.in_ready",  32'(r1),    32'(e.rdy));
      chk("u1.syn_start", 32'(st1),   32'(e.st));
      chk("u1.syn_ce",    32'(ce1),   32'(e.ce));
      chk("u1.syn_valid", 32'(sv1),   32'(e.sv));
      chk("u1.busy",      32'(busy1), 32'(e.busy));
      chk("u1.beat",      32'(beat1), 32'(e.beat));
      chk("u1.syn_data",  32'(sd1),   32'(e.sd[0]));
      if (sv1 && !psv1) begin
         if (q1.size() == 0) begin
            chk("u1.bank_unexpected", 32'(1), 32'(0));
         end else begin
            x = q1.pop_front();
            chk("u1.bank", 32'(bank1[14:0]), 32'(x));
         end
      end
      psv1 = sv1;
      if (st1) begin
         bank1 = '0; bank1[0] = sd1[0]; pos1 = 1;
      end else if (ce1 && pos1 < 16) begin
         bank1[pos1] = sd1[0]; pos1++;
      end
      if (st1) stc1++;
      if (ce1) cec1++;
      if (rst_n) adv(cnt1, held1, ab1, e.fire, ack1, 15);
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      logic [14:0] x;
      if (!rst_n) begin
         cnt4 = 0; held4 = 0; pos4 = 0; psv4 = 0; q4.delete();
      end
      e = mdl(cnt4, held4, v4, ack4, ab4, d4, 4);
      chk("u4.in_ready",  32'(r4),    32'(e.rdy));
      chk("u4.syn_start", 32'(st4),   32'(e.st));
      chk("u4.syn_ce",    32'(ce4),   32'(e.ce));
      chk("u4.syn_valid", 32'(sv4),   32'(e.sv));
      chk("u4.busy",      32'(busy4), 32'(e.busy));
      chk("u4.beat",      32'(beat4), 32'(e.beat));
      chk("u4.syn_data",  32'(sd4),   32'(e.sd));
      if (sv4 && !psv4) begin
         if (q4.size() == 0) begin
            chk("u4.bank_unexpected", 32'(1), 32'(0));
         end else begin
            x = q4.pop_front();
            chk("u4.bank", 32'(bank4), 32'({1'b0, x}));
         end
      end
      psv4 = sv4;
      if (st4) begin
         bank4 = '0; bank4[3:0] = sd4; pos4 = 4;
      end else if (ce4 && pos4 <= 12) begin
         bank4[pos4 +: 4] = sd4; pos4 += 4;
      end
      if (rst_n) adv(cnt4, held4, ab4, e.fire, ack4, 4);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int w, input bit v, input logic [3:0] d);
      if (w == 1) begin v1 = v; d1 = d[0]; end
      else begin v4 = v; d4 = d; end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Send nb beats of codeword cw; mode 2 randomises ack4 every cycle.
   task automatic send(input int w, input logic [14:0] cw, input int max_gap,
                       input int mode, input int nb);
      logic [15:0] cwx;
      logic [3:0]  dat;
      int gap, budget, beats;
      bit fired;
      cwx = {1'b0, cw};
      beats = (w == 1) ? 15 : 4;
      for (int b = 0; b < nb; b++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            drive(w, 1'b0, 4'($urandom));
            tick();
            if (mode == 2) ack4 = 1'($urandom);
         end
         if (w == 1) dat = {3'b0, cwx[b]};
         else begin
            dat = cwx[b*4 +: 4];
            if (b == 3) dat[3] = 1'($urandom);
         end
         drive(w, 1'b1, dat);
         fired = 0;
         budget = 0;
         while (!fired && budget < 200) begin
            @(negedge clk);
            fired = (w == 1) ? (v1 && r1) : (v4 && r4);
            tick();
            if (mode == 2) ack4 = 1'($urandom);
            budget++;
         end
         if (!fired) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut %0d beat %0d accepted 0 required 1", w, b);
            drive(w, 1'b0, 4'h0);
            return;
         end
      end
      drive(w, 1'b0, 4'h0);
      if (nb == beats) begin
         if (w == 1) q1.push_back(cw);
         else q4.push_back(cw);
      end
   endtask

   typedef struct {
      bit v; logic [3:0] d; bit ack;
      bit rdy, st, ce, sv, busy; int beat; logic [3:0] sd;
   } vec_t;
   vec_t tbl[13];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int c0;
      //           v  d     ack rdy st ce sv busy beat sd
      tbl[0]  = '{1, 4'hF, 0,  1,  1, 0, 0, 0,   0,   4'hF};
      tbl[1]  = '{1, 4'hF, 0,  1,  0, 1, 0, 1,   1,   4'hF};
      tbl[2]  = '{0, 4'hF, 0,  1,  0, 0, 0, 1,   2,   4'hF};
      tbl[3]  = '{1, 4'hF, 0,  1,  0, 1, 0, 1,   2,   4'hF};
      tbl[4]  = '{1, 4'hF, 0,  1,  0, 1, 0, 1,   3,   4'h7};
      tbl[5]  = '{1, 4'hF, 0,  0,  0, 0, 1, 0,   0,   4'hF};
      tbl[6]  = '{1, 4'hA, 1,  1,  1, 0, 1, 0,   0,   4'hA};
      tbl[7]  = '{0, 4'h0, 0,  1,  0, 0, 0, 1,   1,   4'h0};
      tbl[8]  = '{1, 4'h5, 0,  1,  0, 1, 0, 1,   1,   4'h5};
      tbl[9]  = '{1, 4'h3, 0,  1,  0, 1, 0, 1,   2,   4'h3};
      tbl[10] = '{1, 4'hF, 0,  1,  0, 1, 0, 1,   3,   4'h7};
      tbl[11] = '{0, 4'h0, 1,  1,  0, 0, 1, 0,   0,   4'h0};
      tbl[12] = '{0, 4'h0, 0,  1,  0, 0, 0, 0,   0,   4'h0};

      // Reset values
      @(negedge clk);
      chk("rst.u1.in_ready",  32'(r1),    32'(1));
      chk("rst.u1.syn_start", 32'(st1),   32'(0));
      chk("rst.u1.syn_ce",    32'(ce1),   32'(0));
      chk("rst.u1.syn_valid", 32'(sv1),   32'(0));
      chk("rst.u1.busy",      32'(busy1), 32'(0));
      chk("rst.u4.beat",      32'(beat4), 32'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // One bit per beat, codeword 15'h0001, no ack
      stc1 = 0; cec1 = 0;
      send(1, 15'h0001, 0, 0, 15);
      chk("u1.start_count", 32'(stc1), 32'(1));
      chk("u1.ce_count",    32'(cec1), 32'(14));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("u1.hold_valid", 32'(sv1), 32'(1));
         chk("u1.hold_ready", 32'(r1),  32'(0));
         tick();
      end
      ack1 = 1'b1; tick(); ack1 = 1'b0;
      @(negedge clk);
      chk("u1.released", 32'(sv1), 32'(0));
      tick();

      // Four bits per beat: table of masking / hold / ack-with-fire cases
      q4.push_back(15'h7FFF);
      q4.push_back(15'h735A);
      for (int i = 0; i < 13; i++) begin
         v4 = tbl[i].v; d4 = tbl[i].d; ack4 = tbl[i].ack;
         @(negedge clk);
         chk($sformatf("tbl%0d.in_ready", i),  32'(r4),    32'(tbl[i].rdy));
         chk($sformatf("tbl%0d.syn_start", i), 32'(st4),   32'(tbl[i].st));
         chk($sformatf("tbl%0d.syn_ce", i),    32'(ce4),   32'(tbl[i].ce));
         chk($sformatf("tbl%0d.syn_valid", i), 32'(sv4),   32'(tbl[i].sv));
         chk($sformatf("tbl%0d.busy", i),      32'(busy4), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d.beat", i),      32'(beat4), 32'(tbl[i].beat));
         chk($sformatf("tbl%0d.syn_data", i),  32'(sd4),   32'(tbl[i].sd));
         tick();
      end
      v4 = 1'b0; ack4 = 1'b0;

      // Random codewords with input gaps and random acknowledgement
      for (int k = 0; k < 20; k++)
         send(4, 15'($urandom), 5, 2, 4);
      ack4 = 1'b1;
      repeat (3) tick();

      // Back-to-back at full rate with ack tied high
      c0 = cyc;
      for (int k = 0; k < 4; k++)
         send(4, 15'($urandom), 0, 0, 4);
      chk("u4.throughput_cycles", 32'(cyc - c0), 32'(16));
      repeat (2) tick();
      ack4 = 1'b0;

      // Reset in the middle of a codeword
      send(1, 15'h5A5A, 0, 0, 8);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst.busy",      32'(busy1), 32'(0));
      chk("midrst.beat",      32'(beat1), 32'(0));
      chk("midrst.in_ready",  32'(r1),    32'(1));
      chk("midrst.syn_valid", 32'(sv1),   32'(0));
      tick();
      rst_n = 1'b1;
      tick();
      send(1, 15'h1234, 0, 0, 15);
      ack1 = 1'b1; tick(); ack1 = 1'b0;
      tick();

`ifdef BCH_SYN_SEQ_ABORT_EN
      // Abort at beat 3 with a concurrent beat offered
      send(4, 15'h0ABC, 0, 0, 3);
      drive(4, 1'b1, 4'hF); ab4 = 1'b1;
      @(negedge clk);
      chk("abort.syn_ce",   32'(ce4),   32'(0));
      chk("abort.in_ready", 32'(r4),    32'(0));
      chk("abort.busy",     32'(busy4), 32'(1));
      tick();
      ab4 = 1'b0;
      drive(4, 1'b1, 4'h5);
      @(negedge clk);
      chk("abort.idle",      32'(busy4), 32'(0));
      chk("abort.beat",      32'(beat4), 32'(0));
      chk("abort.restart",   32'(st4),   32'(1));
      tick();
      drive(4, 1'b1, 4'h6); tick();
      drive(4, 1'b1, 4'h7); tick();
      drive(4, 1'b1, 4'hF); tick();
      drive(4, 1'b0, 4'h0);
      q4.push_back(15'h7765);
      ack4 = 1'b1; tick(); ack4 = 1'b0;
      tick();
`endif

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
